// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and its hazard controller.
// The master side is the datapath, which reports stage contents.
// The slave side is the controller, which returns stall, flush and forwarding controls.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              if_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_multi;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;
    logic              br_taken;

    logic              pc_write;
    logic              ifid_write;
    logic              idex_write;
    logic              ifid_flush;
    logic              idex_flush;
    logic              exmem_flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              v_id;
    logic              v_ex;
    logic              v_mem;
    logic              v_wb;
    logic              busy;

    modport master (
        output if_valid, id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd,
               ex_mem_read, ex_multi, mem_rd, mem_reg_write, wb_rd, wb_reg_write, br_taken,
        input  pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush,
               fwd_a, fwd_b, v_id, v_ex, v_mem, v_wb, busy
    );

    modport slave (
        input  if_valid, id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd,
               ex_mem_read, ex_multi, mem_rd, mem_reg_write, wb_rd, wb_reg_write, br_taken,
        output pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush,
               fwd_a, fwd_b, v_id, v_ex, v_mem, v_wb, busy
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
// It tracks the stage valid bits, stalls on load-use and multi-cycle EX ops,
// flushes younger stages on a taken branch and selects EX operand forwarding.
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int MULTI_CYCLES = 4,
    parameter int BR_IN_MEM    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int CW = $clog2(MULTI_CYCLES) + 1;
    // Last EX cycle of a multi-cycle op; once cnt reaches it the op leaves EX.
    localparam logic [CW-1:0] CNT_LAST = CW'(MULTI_CYCLES - 1);

    logic          v_id;
    logic          v_ex;
    logic          v_mem;
    logic          v_wb;
    logic [CW-1:0] cnt;

    logic stall_m;
    logic lu;
    logic br_flush_mem;

    // Pick the EX operand source. MEM has priority over WB because it holds the younger result.
    // Register 0 and invalid stages are never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              vm,
        input logic              mw,
        input logic [REG_AW-1:0] mrd,
        input logic              vw,
        input logic              ww,
        input logic [REG_AW-1:0] wrd
    );
        if (vm && mw && (mrd != '0) && (mrd == src))
            return 2'b10;
        else if (vw && ww && (wrd != '0) && (wrd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Hazard detection and pipeline control; reset dominates, then branch, then multi-cycle, then load-use.
    always_comb begin
        stall_m          = 1'b0;
        lu               = 1'b0;
        br_flush_mem     = (BR_IN_MEM != 0) ? bus.br_taken : 1'b0;
        bus.pc_write     = 1'b0;
        bus.ifid_write   = 1'b0;
        bus.idex_write   = 1'b0;
        bus.ifid_flush   = 1'b1;
        bus.idex_flush   = 1'b1;
        bus.exmem_flush  = 1'b1;
        bus.busy         = 1'b0;
        bus.fwd_a        = 2'b00;
        bus.fwd_b        = 2'b00;
        if (!reset) begin
            stall_m = v_ex && bus.ex_multi && (cnt < CNT_LAST) && !bus.br_taken;
            lu      = v_id && v_ex && bus.ex_mem_read && (bus.ex_rd != '0)
                      && ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)))
                      && !bus.br_taken && !stall_m;
            bus.pc_write    = !stall_m && !lu;
            bus.ifid_write  = !stall_m && !lu;
            bus.idex_write  = !stall_m;
            bus.ifid_flush  = bus.br_taken;
            bus.idex_flush  = bus.br_taken || lu;
            bus.exmem_flush = stall_m || br_flush_mem;
            bus.busy        = stall_m;
            bus.fwd_a = fwd_sel(bus.ex_rs, v_mem, bus.mem_reg_write, bus.mem_rd,
                                v_wb, bus.wb_reg_write, bus.wb_rd);
            bus.fwd_b = fwd_sel(bus.ex_rt, v_mem, bus.mem_reg_write, bus.mem_rd,
                                v_wb, bus.wb_reg_write, bus.wb_rd);
        end
    end

    // Stage valid bits and multi-cycle occupancy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_id  <= 1'b0;
            v_ex  <= 1'b0;
            v_mem <= 1'b0;
            v_wb  <= 1'b0;
            cnt   <= '0;
        end else begin
            v_wb  <= v_mem;
            v_mem <= v_ex && !bus.exmem_flush;
            v_ex  <= stall_m ? v_ex : (v_id && !bus.idex_flush);
            if (bus.br_taken)
                v_id <= 1'b0;
            else if (!(stall_m || lu))
                v_id <= bus.if_valid;
            cnt   <= stall_m ? cnt + 1'b1 : '0;
        end
    end

    assign bus.v_id  = v_id;
    assign bus.v_ex  = v_ex;
    assign bus.v_mem = v_mem;
    assign bus.v_wb  = v_wb;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (REG_AW=5, MULTI_CYCLES=4, BR_IN_MEM=1).
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(5)) bus ();

    pipeline_hazard_ctrl #(
        .REG_AW(5),
        .MULTI_CYCLES(4),
        .BR_IN_MEM(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // A multi-cycle op sits in EX now with cnt=0: busy for 3 cycles, then it advances.
    task automatic multi_run(input string tag);
        bus.ex_multi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk({tag, "_busy"}, 8'(bus.busy), 8'd1);
            chk({tag, "_exmem_flush"}, 8'(bus.exmem_flush), 8'd1);
            chk({tag, "_pc_write"}, 8'(bus.pc_write), 8'd0);
            tick();
            chk({tag, "_v_mem_bubble"}, 8'(bus.v_mem), 8'd0);
        end
        settle();
        chk({tag, "_busy_end"}, 8'(bus.busy), 8'd0);
        chk({tag, "_pc_write_end"}, 8'(bus.pc_write), 8'd1);
        chk({tag, "_idex_write_end"}, 8'(bus.idex_write), 8'd1);
        tick();
        bus.ex_multi = 1'b0;
        settle();
        chk({tag, "_v_mem_adv"}, 8'(bus.v_mem), 8'd1);
    endtask

    initial begin
        reset = 1'b1;
        bus.if_valid = 1'b1; bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
        bus.ex_rs = '0; bus.ex_rt = '0; bus.ex_rd = '0; bus.ex_mem_read = 1'b0;
        bus.ex_multi = 1'b0; bus.mem_rd = '0; bus.mem_reg_write = 1'b0;
        bus.wb_rd = '0; bus.wb_reg_write = 1'b0; bus.br_taken = 1'b0;

        // Reset state
        settle();
        chk("rst_pc_write", 8'(bus.pc_write), 8'd0);
        chk("rst_ifid_write", 8'(bus.ifid_write), 8'd0);
        chk("rst_idex_write", 8'(bus.idex_write), 8'd0);
        chk("rst_flushes", {5'd0, bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 8'h07);
        tick(); tick();
        chk("rst_valids", {4'd0, bus.v_id, bus.v_ex, bus.v_mem, bus.v_wb}, 8'h00);
        chk("rst_fwd", {4'd0, bus.fwd_a, bus.fwd_b}, 8'h00);

        // Fill IF->ID->EX
        reset = 1'b0;
        tick(); tick();
        chk("fill_valids", {4'd0, bus.v_id, bus.v_ex, bus.v_mem, bus.v_wb}, 8'h0C);

        // T1: lw $2 in EX, add $3,$2,$4 in ID
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd2; bus.id_rs = 5'd2;
        settle();
        chk("t1_pc_write", 8'(bus.pc_write), 8'd0);
        chk("t1_ifid_write", 8'(bus.ifid_write), 8'd0);
        chk("t1_idex_flush", 8'(bus.idex_flush), 8'd1);
        chk("t1_idex_write", 8'(bus.idex_write), 8'd1);
        tick();
        // load now in MEM, bubble in EX, add held in ID
        bus.ex_mem_read = 1'b0; bus.ex_rd = 5'd0;
        bus.mem_rd = 5'd2; bus.mem_reg_write = 1'b1;
        settle();
        chk("t1_bubble_valids", {4'd0, bus.v_id, bus.v_ex, bus.v_mem, bus.v_wb}, 8'h0A);
        chk("t1_pc_resume", 8'(bus.pc_write), 8'd1);
        tick();
        // add in EX, bubble in MEM, load in WB
        bus.mem_rd = 5'd0; bus.mem_reg_write = 1'b0;
        bus.wb_rd = 5'd2; bus.wb_reg_write = 1'b1; bus.ex_rs = 5'd2;
        settle();
        chk("t1_valids_after", {4'd0, bus.v_id, bus.v_ex, bus.v_mem, bus.v_wb}, 8'h0D);
        chk("t1_fwd_a", 8'(bus.fwd_a), 8'h01);
        bus.wb_rd = 5'd0; bus.wb_reg_write = 1'b0; bus.ex_rs = 5'd0; bus.id_rs = 5'd0;
        tick(); tick();
        chk("full_valids", {4'd0, bus.v_id, bus.v_ex, bus.v_mem, bus.v_wb}, 8'h0F);

        // Load-use boundary cases: $0 destination, rt only when used
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0;
        settle();
        chk("lu_reg0", 8'(bus.pc_write), 8'd1);
        bus.ex_rd = 5'd3; bus.id_rs = 5'd1; bus.id_rt = 5'd3; bus.id_uses_rt = 1'b0;
        settle();
        chk("lu_rt_unused", 8'(bus.pc_write), 8'd1);
        bus.id_uses_rt = 1'b1;
        settle();
        chk("lu_rt_used", 8'(bus.pc_write), 8'd0);
        bus.ex_mem_read = 1'b0; bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        bus.id_uses_rt = 1'b0;

        // T4: MEM beats WB, register 0 not forwarded
        bus.mem_rd = 5'd5; bus.wb_rd = 5'd5; bus.ex_rs = 5'd5; bus.ex_rt = 5'd5;
        bus.mem_reg_write = 1'b1; bus.wb_reg_write = 1'b1;
        settle();
        chk("t4_fwd_a_mem", 8'(bus.fwd_a), 8'h02);
        chk("t4_fwd_b_mem", 8'(bus.fwd_b), 8'h02);
        bus.mem_rd = 5'd0; bus.ex_rs = 5'd0; bus.wb_rd = 5'd0;
        settle();
        chk("t4_fwd_a_reg0", 8'(bus.fwd_a), 8'h00);
        bus.mem_rd = 5'd5; bus.wb_rd = 5'd5; bus.ex_rs = 5'd5;

        // T3: taken branch resolved in MEM
        bus.br_taken = 1'b1;
        settle();
        chk("t3_flushes", {5'd0, bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 8'h07);
        chk("t3_pc_write", 8'(bus.pc_write), 8'd1);
        tick();
        bus.br_taken = 1'b0;
        settle();
        chk("t3_valids", {4'd0, bus.v_id, bus.v_ex, bus.v_mem, bus.v_wb}, 8'h01);
        chk("t3_pc_write_next", 8'(bus.pc_write), 8'd1);

        // T4 cont.: MEM invalid so WB wins; WB reg0 not forwarded
        chk("t4_fwd_a_wb", 8'(bus.fwd_a), 8'h01);
        chk("t4_fwd_b_wb", 8'(bus.fwd_b), 8'h01);
        bus.wb_rd = 5'd0;
        settle();
        chk("t4_fwd_a_none", 8'(bus.fwd_a), 8'h00);
        bus.mem_rd = 5'd0; bus.ex_rs = 5'd0; bus.ex_rt = 5'd0;
        bus.mem_reg_write = 1'b0; bus.wb_reg_write = 1'b0;

        // T2: 4-cycle op in EX
        tick(); tick();
        chk("t2_v_ex", 8'(bus.v_ex), 8'd1);
        multi_run("t2");

        // T6: branch during multi-cycle stall
        bus.ex_multi = 1'b1;
        settle();
        chk("t6_busy", 8'(bus.busy), 8'd1);
        tick();
        bus.br_taken = 1'b1;
        settle();
        chk("t6_busy_br", 8'(bus.busy), 8'd0);
        chk("t6_pc_write", 8'(bus.pc_write), 8'd1);
        chk("t6_exmem_flush", 8'(bus.exmem_flush), 8'd1);
        tick();
        bus.br_taken = 1'b0; bus.ex_multi = 1'b0;
        settle();
        chk("t6_valids", {4'd0, bus.v_id, bus.v_ex, bus.v_mem, bus.v_wb}, 8'h00);
        tick(); tick();
        multi_run("t6_full");

        // T5: reset in cycle 2 of a stall
        bus.ex_multi = 1'b1;
        tick();
        settle();
        chk("t5_busy_pre", 8'(bus.busy), 8'd1);
        reset = 1'b1;
        settle();
        chk("t5_busy_rst", 8'(bus.busy), 8'd0);
        chk("t5_pc_write_rst", 8'(bus.pc_write), 8'd0);
        chk("t5_ifid_flush_rst", 8'(bus.ifid_flush), 8'd1);
        tick();
        chk("t5_valids", {4'd0, bus.v_id, bus.v_ex, bus.v_mem, bus.v_wb}, 8'h00);
        chk("t5_busy_after", 8'(bus.busy), 8'd0);
        reset = 1'b0;
        bus.ex_multi = 1'b0;
        tick(); tick();
        multi_run("t5_full");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
